// File: rtl/sata_prim_decoder.sv
// Dword-level SATA primitive decoder: classifies aligned dwords as primitive,
// data or error, expands CONTp repetition and counts 8b/10b decode errors.
module sata_prim_decoder #(
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     isaligned_in,
   input  logic [3:0]               charisk_in,
   input  logic [3:0]               notintable_in,
   input  logic [3:0]               disperror_in,
   input  logic [31:0]              data_in,
   input  logic                     err_cnt_clr,
   output logic                     prim_valid,
   output logic [4:0]               prim_id,
   output logic                     prim_cont,
   output logic                     data_valid,
   output logic [31:0]              data_out,
   output logic                     dec_err,
   output logic                     unknown_prim,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_CONT   = 1'b1
   } state_t;

   localparam int         NUM_PRIM = 18;
   localparam logic [4:0] ID_NONE  = 5'd0;
   localparam logic [4:0] ID_ALIGN = 5'd1;
   localparam logic [4:0] ID_CONT  = 5'd2;

   // Entry n holds the dword for prim_id n+1.
   localparam logic [31:0] PRIM_TABLE [NUM_PRIM] = '{
      32'h7B4A4ABC,   // ALIGN
      32'h9999AA7C,   // CONT
      32'h3636B57C,   // DMAT
      32'hD5D5B57C,   // EOF
      32'hD5D5AA7C,   // HOLD
      32'h9595AA7C,   // HOLDA
      32'h9595957C,   // PMACK
      32'hF5F5957C,   // PMNAK
      32'h1717B57C,   // PMREQ_P
      32'h7575957C,   // PMREQ_S
      32'h5656B57C,   // R_ERR
      32'h5555B57C,   // R_IP
      32'h3535B57C,   // R_OK
      32'h4A4A957C,   // R_RDY
      32'h3737B57C,   // SOF
      32'hB5B5957C,   // SYNC
      32'h5858B57C,   // WTRM
      32'h5757B57C    // X_RDY
   };

   state_t                   state_q, state_d;
   logic [4:0]               held_q, held_d;
   logic                     prim_valid_q, prim_valid_d;
   logic [4:0]               prim_id_q, prim_id_d;
   logic                     prim_cont_q, prim_cont_d;
   logic                     data_valid_q, data_valid_d;
   logic [31:0]              data_out_q, data_out_d;
   logic                     dec_err_q, dec_err_d;
   logic                     unknown_q, unknown_d;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

   logic [NUM_PRIM-1:0] hit;
   logic [4:0]          lookup_id;
   logic [4:0]          match_id;
   logic                err_in;
   logic                unknown_in;
   logic                is_align;
   logic                is_cont;
   logic                is_other;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PRIM; gi++) begin : g_match
         assign hit[gi] = (data_in == PRIM_TABLE[gi]);
      end
   endgenerate

   // Table entries are distinct, so at most one hit bit is set and OR-encoding is exact.
   always_comb begin
      lookup_id = ID_NONE;
      for (int i = 0; i < NUM_PRIM; i++) begin
         if (hit[i]) begin
            lookup_id = lookup_id | 5'(i + 1);
         end
      end
   end

   assign err_in     = (|notintable_in) | (|disperror_in);
   assign match_id   = (charisk_in == 4'h1 && !err_in) ? lookup_id : ID_NONE;
   assign unknown_in = (charisk_in != 4'h0) && !err_in && (match_id == ID_NONE);
   assign is_align   = (match_id == ID_ALIGN);
   assign is_cont    = (match_id == ID_CONT);
   assign is_other   = (match_id != ID_NONE) && !is_align && !is_cont;

   always_comb begin
      state_d      = state_q;
      held_d       = held_q;
      prim_valid_d = 1'b0;
      prim_id_d    = ID_NONE;
      prim_cont_d  = 1'b0;
      data_valid_d = 1'b0;
      data_out_d   = 32'h0;
      dec_err_d    = 1'b0;
      unknown_d    = 1'b0;

      if (!isaligned_in) begin
         state_d = ST_NORMAL;
         held_d  = ID_NONE;
      end else begin
         dec_err_d = err_in;
         unknown_d = unknown_in;
         case (state_q)
            ST_NORMAL: begin
               if (err_in) begin
                  // Corrupted payload still forwarded; CRC rejects it downstream.
                  data_valid_d = 1'b1;
                  data_out_d   = data_in;
               end else if (is_align) begin
                  prim_valid_d = 1'b1;
                  prim_id_d    = ID_ALIGN;
               end else if (is_cont) begin
                  prim_valid_d = 1'b1;
                  if (held_q != ID_NONE) begin
                     state_d     = ST_CONT;
                     prim_id_d   = held_q;
                     prim_cont_d = 1'b1;
                  end else begin
                     prim_id_d   = ID_CONT;
                  end
               end else if (is_other) begin
                  prim_valid_d = 1'b1;
                  prim_id_d    = match_id;
                  held_d       = match_id;
               end else if (charisk_in == 4'h0) begin
                  data_valid_d = 1'b1;
                  data_out_d   = data_in;
               end
            end
            ST_CONT: begin
               if (is_align) begin
                  prim_valid_d = 1'b1;
                  prim_id_d    = ID_ALIGN;
               end else if (is_other) begin
                  state_d      = ST_NORMAL;
                  prim_valid_d = 1'b1;
                  prim_id_d    = match_id;
                  held_d       = match_id;
               end else begin
                  // Scrambled filler, repeated CONTs and bad dwords all repeat the held primitive.
                  prim_valid_d = 1'b1;
                  prim_id_d    = held_q;
                  prim_cont_d  = 1'b1;
               end
            end
            default: state_d = ST_NORMAL;
         endcase
      end
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_cnt_clr) begin
         err_cnt_d = '0;
      end else if (isaligned_in && (err_in || unknown_in) && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_NORMAL;
         held_q       <= ID_NONE;
         prim_valid_q <= 1'b0;
         prim_id_q    <= ID_NONE;
         prim_cont_q  <= 1'b0;
         data_valid_q <= 1'b0;
         data_out_q   <= 32'h0;
         dec_err_q    <= 1'b0;
         unknown_q    <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         held_q       <= held_d;
         prim_valid_q <= prim_valid_d;
         prim_id_q    <= prim_id_d;
         prim_cont_q  <= prim_cont_d;
         data_valid_q <= data_valid_d;
         data_out_q   <= data_out_d;
         dec_err_q    <= dec_err_d;
         unknown_q    <= unknown_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign prim_valid   = prim_valid_q;
   assign prim_id      = prim_id_q;
   assign prim_cont    = prim_cont_q;
   assign data_valid   = data_valid_q;
   assign data_out     = data_out_q;
   assign dec_err      = dec_err_q;
   assign unknown_prim = unknown_q;
   assign err_cnt      = err_cnt_q;

endmodule
